alu_16bit: RTL and testbench



---
 rtl/alu_16bit_if.sv | 56 +++++
 rtl/alu_16bit.sv | 167 ++++++++++++++++
 tb/tb_alu_16bit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_16bit_if.sv
// -----------------------------------------------------------------------------
// alu_16bit_if
// Operand/result bundle between the register file / controller and the ALU.
//
// Signals (WIDTH = operand width, result is WIDTH+1 bits):
//   a, b        operands from the register file
//   alu_fun     4-bit operation select
//   alu_out     registered WIDTH+1 bit result
//   Arith_flag  operation class 0-3   (combinational decode of alu_fun)
//   Logic_flag  operation class 4-9
//   CMP_flag    operation class 10-12
//   Shift_flag  operation class 13-14
// With ALU_ENABLE_EN defined:
//   enable      capture qualifier for alu_out
//   out_valid   high for the cycle after a qualified capture
//
// Modports: master = register file / controller side, slave = ALU side.
// -----------------------------------------------------------------------------
interface alu_16bit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_fun;
    logic [WIDTH:0]   alu_out;
    logic             Arith_flag;
    logic             Logic_flag;
    logic             CMP_flag;
    logic             Shift_flag;
`ifdef ALU_ENABLE_EN
    logic             enable;
    logic             out_valid;
`endif

`ifdef ALU_ENABLE_EN
    modport master (
        output a, b, alu_fun, enable,
        input  alu_out, Arith_flag, Logic_flag, CMP_flag, Shift_flag, out_valid
    );

    modport slave (
        input  a, b, alu_fun, enable,
        output alu_out, Arith_flag, Logic_flag, CMP_flag, Shift_flag, out_valid
    );
`else
    modport master (
        output a, b, alu_fun,
        input  alu_out, Arith_flag, Logic_flag, CMP_flag, Shift_flag
    );

    modport slave (
        input  a, b, alu_fun,
        output alu_out, Arith_flag, Logic_flag, CMP_flag, Shift_flag
    );
`endif
endinterface : alu_16bit_if

// File: rtl/alu_16bit.sv
// -----------------------------------------------------------------------------
// alu_16bit
// Registered ALU with 16 operations selected by a 4-bit function code.
// Operands are zero-extended to WIDTH+1 bits, the result is computed
// combinationally and captured on the rising clock edge (one-cycle latency).
// The four class flags are a pure combinational decode of alu_fun and are
// not touched by reset.
//
// Ports:
//   clk    system clock, rising edge active
//   rst_n  asynchronous active-low reset, clears alu_out (and out_valid)
//   bus    alu_16bit_if.slave: a, b, alu_fun in; alu_out and flags out
//
// Optional feature macro: ALU_ENABLE_EN
//   Defined   -> bus.enable qualifies the capture, bus.out_valid reports it.
//   Undefined -> alu_out captures a new result on every rising edge.
// -----------------------------------------------------------------------------
module alu_16bit #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_16bit_if.slave     bus
);

    localparam logic [WIDTH:0] RES_ZERO = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0] RES_EQ   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] RES_GT   = {{(WIDTH-1){1'b0}}, 2'b10};
    localparam logic [WIDTH:0] RES_LT   = {{(WIDTH-1){1'b0}}, 2'b11};

    // Operation codes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_XNOR = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd10;
    localparam logic [3:0] OP_GT   = 4'd11;
    localparam logic [3:0] OP_LT   = 4'd12;
    localparam logic [3:0] OP_SHR  = 4'd13;
    localparam logic [3:0] OP_SHL  = 4'd14;
    localparam logic [3:0] OP_NOP  = 4'd15;

    logic [WIDTH:0] a_ext_s;
    logic [WIDTH:0] b_ext_s;
    logic [WIDTH:0] result_s;
    logic           arith_s;
    logic           logic_s;
    logic           cmp_s;
    logic           shift_s;
    logic [WIDTH:0] alu_out_r;
`ifdef ALU_ENABLE_EN
    logic           out_valid_r;
`endif

    // Zero-extend both operands so every operation works on WIDTH+1 bits;
    // the inverting logic ops therefore set the top bit.
    assign a_ext_s = {1'b0, bus.a};
    assign b_ext_s = {1'b0, bus.b};

    // Result datapath: all arithmetic wraps/truncates to WIDTH+1 bits.
    always_comb begin
        result_s = RES_ZERO;
        case (bus.alu_fun)
            OP_ADD:  result_s = a_ext_s + b_ext_s;
            OP_SUB:  result_s = a_ext_s - b_ext_s;
            OP_MUL:  result_s = a_ext_s * b_ext_s;
            OP_DIV: begin
                // Divide-by-zero is defined to return zero.
                if (b_ext_s == RES_ZERO) begin
                    result_s = RES_ZERO;
                end else begin
                    result_s = a_ext_s / b_ext_s;
                end
            end
            OP_AND:  result_s = a_ext_s & b_ext_s;
            OP_OR:   result_s = a_ext_s | b_ext_s;
            OP_NAND: result_s = ~(a_ext_s & b_ext_s);
            OP_NOR:  result_s = ~(a_ext_s | b_ext_s);
            OP_XOR:  result_s = a_ext_s ^ b_ext_s;
            OP_XNOR: result_s = ~(a_ext_s ^ b_ext_s);
            OP_EQ: begin
                if (bus.a == bus.b) begin
                    result_s = RES_EQ;
                end else begin
                    result_s = RES_ZERO;
                end
            end
            OP_GT: begin
                if (bus.a > bus.b) begin
                    result_s = RES_GT;
                end else begin
                    result_s = RES_ZERO;
                end
            end
            OP_LT: begin
                if (bus.a < bus.b) begin
                    result_s = RES_LT;
                end else begin
                    result_s = RES_ZERO;
                end
            end
            // Logical right shift: zero fills the vacated MSBs.
            OP_SHR:  result_s = {2'b00, bus.a[WIDTH-1:1]};
            // Left shift into the extra bit: a's MSB lands in bit WIDTH.
            OP_SHL:  result_s = {bus.a, 1'b0};
            OP_NOP:  result_s = RES_ZERO;
            default: result_s = RES_ZERO;
        endcase
    end

    // Operation-class decode; one-hot, all low for the no-op code.
    always_comb begin
        arith_s = 1'b0;
        logic_s = 1'b0;
        cmp_s   = 1'b0;
        shift_s = 1'b0;
        case (bus.alu_fun)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV:                     arith_s = 1'b1;
            OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR:    logic_s = 1'b1;
            OP_EQ, OP_GT, OP_LT:                                cmp_s   = 1'b1;
            OP_SHR, OP_SHL:                                     shift_s = 1'b1;
            OP_NOP:                                             arith_s = 1'b0;
            default:                                            arith_s = 1'b0;
        endcase
    end

    assign bus.Arith_flag = arith_s;
    assign bus.Logic_flag = logic_s;
    assign bus.CMP_flag   = cmp_s;
    assign bus.Shift_flag = shift_s;

`ifdef ALU_ENABLE_EN
    // Result register, qualified by enable; out_valid marks a fresh capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_r   <= RES_ZERO;
            out_valid_r <= 1'b0;
        end else if (bus.enable) begin
            alu_out_r   <= result_s;
            out_valid_r <= 1'b1;
        end else begin
            alu_out_r   <= alu_out_r;
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
`else
    // Result register, captures every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_r <= RES_ZERO;
        end else begin
            alu_out_r <= result_s;
        end
    end
`endif

    assign bus.alu_out = alu_out_r;

endmodule : alu_16bit

// File: tb/tb_alu_16bit.sv
// -----------------------------------------------------------------------------
// tb_alu_16bit
// Table-driven self-checking bench for alu_16bit plus short hand-written
// sequences for reset, hold-between-edges, mid-cycle code change and the
// optional enable qualifier (ALU_ENABLE_EN).
// -----------------------------------------------------------------------------
module tb_alu_16bit;

    localparam int WIDTH = 16;

    // Flag nibble order: {Arith, Logic, CMP, Shift}
    localparam logic [3:0] F_A = 4'b1000;
    localparam logic [3:0] F_L = 4'b0100;
    localparam logic [3:0] F_C = 4'b0010;
    localparam logic [3:0] F_S = 4'b0001;
    localparam logic [3:0] F_N = 4'b0000;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
        logic [16:0] exp_out;
        logic [3:0]  exp_flags;
    } vec_t;

    localparam int NVEC = 27;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    vec_t vecs [NVEC];
    logic [16:0] held;

    alu_16bit_if #(.WIDTH(WIDTH)) bus_if ();

    alu_16bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus_if.Arith_flag, bus_if.Logic_flag, bus_if.CMP_flag, bus_if.Shift_flag};
    endfunction

    task automatic set_vec(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
        bus_if.a       = a;
        bus_if.b       = b;
        bus_if.alu_fun = fun;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        vecs[0]  = '{16'd15,    16'd10,    4'd1,  17'd5,      F_A};
        vecs[1]  = '{16'd15,    16'd10,    4'd2,  17'd150,    F_A};
        vecs[2]  = '{16'd15,    16'd10,    4'd3,  17'd1,      F_A};
        vecs[3]  = '{16'd15,    16'd10,    4'd4,  17'd10,     F_L};
        vecs[4]  = '{16'd15,    16'd10,    4'd5,  17'd15,     F_L};
        vecs[5]  = '{16'd15,    16'd10,    4'd6,  17'd131061, F_L};
        vecs[6]  = '{16'd15,    16'd10,    4'd7,  17'd131056, F_L};
        vecs[7]  = '{16'd15,    16'd10,    4'd8,  17'd5,      F_L};
        vecs[8]  = '{16'd15,    16'd10,    4'd9,  17'd131066, F_L};
        vecs[9]  = '{16'd15,    16'd10,    4'd10, 17'd0,      F_C};
        vecs[10] = '{16'd15,    16'd10,    4'd11, 17'd2,      F_C};
        vecs[11] = '{16'd15,    16'd10,    4'd12, 17'd0,      F_C};
        vecs[12] = '{16'd7,     16'd7,     4'd10, 17'd1,      F_C};
        vecs[13] = '{16'd3,     16'd9,     4'd12, 17'd3,      F_C};
        vecs[14] = '{16'd15,    16'd10,    4'd13, 17'd7,      F_S};
        vecs[15] = '{16'd15,    16'd10,    4'd14, 17'd30,     F_S};
        vecs[16] = '{16'd15,    16'd10,    4'd15, 17'd0,      F_N};
        vecs[17] = '{16'h8000,  16'd0,     4'd14, 17'd65536,  F_S};
        vecs[18] = '{16'd3,     16'd0,     4'd3,  17'd0,      F_A};
        vecs[19] = '{16'd5,     16'd10,    4'd1,  17'd131067, F_A};
        vecs[20] = '{16'hFFFF,  16'hFFFF,  4'd0,  17'd131070, F_A};
        vecs[21] = '{16'hFFFF,  16'hFFFF,  4'd2,  17'd1,      F_A};
        vecs[22] = '{16'hFFFF,  16'd2,     4'd2,  17'd131070, F_A};
        vecs[23] = '{16'd9,     16'd9,     4'd11, 17'd0,      F_C};
        vecs[24] = '{16'd9,     16'd9,     4'd12, 17'd0,      F_C};
        vecs[25] = '{16'd100,   16'd7,     4'd3,  17'd14,     F_A};
        vecs[26] = '{16'hFFFF,  16'd0,     4'd13, 17'd32767,  F_S};

        // Reset with inputs already presenting a valid add: output stays 0
        // without any clock edge, flags are live regardless of reset.
        rst_n = 1'b0;
`ifdef ALU_ENABLE_EN
        bus_if.enable = 1'b1;
`endif
        set_vec(16'd15, 16'd10, 4'd0);
        #3;
        check("reset_out_no_clock", 32'(bus_if.alu_out), 32'd0);
        check("flags_in_reset", 32'(flags_now()), 32'(F_A));
`ifdef ALU_ENABLE_EN
        check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
`endif
        @(posedge clk);
        #1;
        check("reset_holds_over_edge", 32'(bus_if.alu_out), 32'd0);

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_add", 32'(bus_if.alu_out), 32'd25);
        check("first_add_flag", 32'(flags_now()), 32'(F_A));

        // Table: flags checked before the edge, result one edge later.
        for (int i = 0; i < NVEC; i++) begin
            set_vec(vecs[i].a, vecs[i].b, vecs[i].fun);
            #1;
            check($sformatf("flags[%0d]", i), 32'(flags_now()), 32'(vecs[i].exp_flags));
            @(posedge clk);
            #1;
            check($sformatf("out[%0d]", i), 32'(bus_if.alu_out), 32'(vecs[i].exp_out));
        end

        // Output holds between edges even when inputs change.
        held = bus_if.alu_out;
        set_vec(16'd1, 16'd2, 4'd0);
        #3;
        check("hold_between_edges", 32'(bus_if.alu_out), 32'(held));

        // Mid-cycle code change: only the value present at the edge counts.
        set_vec(16'd15, 16'd10, 4'd0);
        #2;
        bus_if.alu_fun = 4'd8;
        @(posedge clk);
        #1;
        check("mid_cycle_fun_change", 32'(bus_if.alu_out), 32'd5);

        // Asynchronous reset in the middle of a cycle overrides the capture.
        set_vec(16'd200, 16'd100, 4'd0);
        @(posedge clk);
        #1;
        check("pre_reset_value", 32'(bus_if.alu_out), 32'd300);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_cycle", 32'(bus_if.alu_out), 32'd0);
        @(posedge clk);
        #1;
        check("reset_blocks_capture", 32'(bus_if.alu_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset_release", 32'(bus_if.alu_out), 32'd300);

`ifdef ALU_ENABLE_EN
        check("valid_after_capture", 32'(bus_if.out_valid), 32'd1);
        // enable low: code changes but result and out_valid do not update.
        bus_if.enable = 1'b0;
        set_vec(16'd15, 16'd10, 4'd2);
        @(posedge clk);
        #1;
        check("en0_hold", 32'(bus_if.alu_out), 32'd300);
        check("en0_valid", 32'(bus_if.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("en0_hold2", 32'(bus_if.alu_out), 32'd300);
        bus_if.enable = 1'b1;
        @(posedge clk);
        #1;
        check("en1_update", 32'(bus_if.alu_out), 32'd150);
        check("en1_valid", 32'(bus_if.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_clears_valid", 32'(bus_if.out_valid), 32'd0);
        rst_n = 1'b1;
`endif

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_16bit
